// File: rtl/t_ff_bank_pkg.sv
// t_ff_bank_pkg: shared types and command encodings for the toggle flip-flop bank arbiter.
// Ports: none (package). Imported by t_ff_bank_arbiter and rr_arbiter.
// Optional lock feature (top level) is enabled by defining T_FF_BANK_ARB_LOCK_EN.
package t_ff_bank_pkg;

   // Two-bit command encodings as seen on req_cmd slices
   localparam logic [1:0] CMD_NOP_ENC    = 2'b00;
   localparam logic [1:0] CMD_TOGGLE_ENC = 2'b01;
   localparam logic [1:0] CMD_SET_ENC    = 2'b10;
   localparam logic [1:0] CMD_RESET_ENC  = 2'b11;

   typedef enum logic [1:0] {
      CMD_NOP    = CMD_NOP_ENC,
      CMD_TOGGLE = CMD_TOGGLE_ENC,
      CMD_SET    = CMD_SET_ENC,
      CMD_RESET  = CMD_RESET_ENC
   } cmd_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, one-hot grant of the first set request at or after start.
// Ports: req (request vector), start (search pointer), grant (one-hot or zero).
// Purely combinational; no state, no clock.
module rr_arbiter
   import t_ff_bank_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] start,
   output logic [N-1:0]         grant
);

   localparam int PW = $clog2(N);

   always_comb begin
      logic [PW-1:0] idx;
      logic          found;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      // Walk N slots beginning at start, wrapping modulo N
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(start) + k) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/t_ff_bank_arbiter.sv
// t_ff_bank_arbiter: WIDTH-bit toggle/set/reset flip-flop bank shared by N_REQ requesters via round-robin.
// Ports: clk, reset (async high), enable, req_valid/req_cmd/req_mask/req_lock in; req_ready, q, locked, owner out.
// Define T_FF_BANK_ARB_LOCK_EN to enable bank locking with a LOCK_MAX idle-cycle timeout; otherwise plain round-robin.
module t_ff_bank_arbiter
   import t_ff_bank_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int N_REQ    = 4,
   parameter int LOCK_MAX = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [2*N_REQ-1:0]       req_cmd,
   input  logic [WIDTH*N_REQ-1:0]   req_mask,
   input  logic [N_REQ-1:0]         req_lock,
   output logic [N_REQ-1:0]         req_ready,
   output logic [WIDTH-1:0]         q,
   output logic                     locked,
   output logic [$clog2(N_REQ)-1:0] owner
);

   localparam int PW = $clog2(N_REQ);

   logic [PW-1:0]    ptr, ptr_nxt;
   logic [WIDTH-1:0] q_r, q_nxt;
   logic [N_REQ-1:0] arb_req, grant;
   logic             xfer;
   logic [PW-1:0]    gnt_idx;
   logic [1:0]       sel_cmd;
   logic [WIDTH-1:0] sel_mask;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
   endfunction

`ifdef T_FF_BANK_ARB_LOCK_EN
   localparam int TW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   state_e        state, state_nxt;
   logic [PW-1:0] owner_r, owner_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          sel_lock;

   // While locked only the owner is allowed to compete
   assign arb_req = (state == ST_LOCKED) ? (req_valid & (N_REQ'(1) << owner_r)) : req_valid;
   assign locked  = (state == ST_LOCKED);
   assign owner   = owner_r;
`else
   logic unused_lock;

   assign unused_lock = ^req_lock;
   assign arb_req     = req_valid;
   assign locked      = 1'b0;
   assign owner       = '0;
`endif

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req   (arb_req),
      .start (ptr),
      .grant (grant)
   );

   // Grant is suppressed outright during reset and while disabled
   assign req_ready = (reset || !enable) ? '0 : grant;
   assign xfer      = |req_ready;
   assign q         = q_r;

   // Select the granted requester's command fields
   always_comb begin
      gnt_idx  = '0;
      sel_cmd  = CMD_NOP_ENC;
      sel_mask = '0;
`ifdef T_FF_BANK_ARB_LOCK_EN
      sel_lock = 1'b0;
`endif
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            gnt_idx  = PW'(i);
            sel_cmd  = req_cmd[2*i +: 2];
            sel_mask = req_mask[WIDTH*i +: WIDTH];
`ifdef T_FF_BANK_ARB_LOCK_EN
            sel_lock = req_lock[i];
`endif
         end
      end
   end

   // Next-state: bank contents, pointer and (optionally) lock FSM
   always_comb begin
      q_nxt   = q_r;
      ptr_nxt = ptr;
`ifdef T_FF_BANK_ARB_LOCK_EN
      state_nxt = state;
      owner_nxt = owner_r;
      timer_nxt = timer;
`endif
      if (xfer) begin
         unique case (cmd_e'(sel_cmd))
            CMD_TOGGLE: q_nxt = q_r ^ sel_mask;
            CMD_SET:    q_nxt = q_r | sel_mask;
            CMD_RESET:  q_nxt = q_r & ~sel_mask;
            default:    q_nxt = q_r;
         endcase
         ptr_nxt = ptr_inc(gnt_idx);
`ifdef T_FF_BANK_ARB_LOCK_EN
         if (state == ST_IDLE) begin
            if (sel_lock) begin
               state_nxt = ST_LOCKED;
               owner_nxt = gnt_idx;
               timer_nxt = '0;
            end
         end else begin
            // A transfer while locked is necessarily from the owner
            timer_nxt = '0;
            if (!sel_lock) begin
               state_nxt = ST_IDLE;
            end
         end
`endif
      end
`ifdef T_FF_BANK_ARB_LOCK_EN
      else if (enable && state == ST_LOCKED) begin
         if (int'(timer) == LOCK_MAX - 1) begin
            // Owner went quiet too long: release and hand priority to the next requester
            state_nxt = ST_IDLE;
            timer_nxt = '0;
            ptr_nxt   = ptr_inc(owner_r);
         end else begin
            timer_nxt = timer + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r <= '0;
         ptr <= '0;
      end else begin
         q_r <= q_nxt;
         ptr <= ptr_nxt;
      end
   end

`ifdef T_FF_BANK_ARB_LOCK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         owner_r <= '0;
         timer   <= '0;
      end else begin
         state   <= state_nxt;
         owner_r <= owner_nxt;
         timer   <= timer_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_t_ff_bank_arbiter.sv
// tb_t_ff_bank_arbiter: directed and randomized checks of t_ff_bank_arbiter against a behavioural model.
// Ports: none (testbench top). Drives inputs on the falling edge, samples grant 1 time unit later.
// Lock scenarios are compiled in when T_FF_BANK_ARB_LOCK_EN is defined.
module tb_t_ff_bank_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int LM = 16;
`ifdef T_FF_BANK_ARB_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           enable;
   logic [N-1:0]   req_valid;
   logic [2*N-1:0] req_cmd;
   logic [W*N-1:0] req_mask;
   logic [N-1:0]   req_lock;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   q;
   logic           locked;
   logic [1:0]     owner;

   t_ff_bank_arbiter #(.WIDTH(W), .N_REQ(N), .LOCK_MAX(LM)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req_valid (req_valid),
      .req_cmd   (req_cmd),
      .req_mask  (req_mask),
      .req_lock  (req_lock),
      .req_ready (req_ready),
      .q         (q),
      .locked    (locked),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Requester-side view of each pending command
   bit         v [N];
   logic [1:0] c [N];
   logic [7:0] m [N];
   bit         l [N];

   // Reference model state
   logic [7:0] m_q;
   int         m_ptr, m_owner, m_timer;
   bit         m_locked;

   int         last_g;
   logic [3:0] last_rdy;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = v[i];
         req_cmd[2*i +: 2]  = c[i];
         req_mask[8*i +: 8] = m[i];
         req_lock[i]        = l[i];
      end
   endtask

   task automatic set_req(input int i, input bit vv, input logic [1:0] cc, input logic [7:0] mm, input bit ll);
      v[i] = vv; c[i] = cc; m[i] = mm; l[i] = ll;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'b00, 8'h00, 1'b0);
   endtask

   task automatic model_reset();
      m_q = 8'h00; m_ptr = 0; m_owner = 0; m_timer = 0; m_locked = 1'b0;
   endtask

   // Who should be granted now, from the rules: first valid eligible requester from the pointer
   function automatic int model_pick();
      if (reset || !enable) return -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (v[i] && (!m_locked || i == m_owner)) return i;
      end
      return -1;
   endfunction

   task automatic model_update(input int g);
      if (!enable) return;
      if (g >= 0) begin
         case (c[g])
            2'b01:   m_q = m_q ^ m[g];
            2'b10:   m_q = m_q | m[g];
            2'b11:   m_q = m_q & ~m[g];
            default: m_q = m_q;
         endcase
         m_ptr = (g + 1) % N;
         if (LOCK_ON) begin
            if (!m_locked && l[g]) begin
               m_locked = 1'b1; m_owner = g; m_timer = 0;
            end else if (m_locked) begin
               m_timer = 0;
               if (!l[g]) m_locked = 1'b0;
            end
         end
      end else if (LOCK_ON && m_locked) begin
         if (m_timer == LM - 1) begin
            m_locked = 1'b0; m_timer = 0; m_ptr = (m_owner + 1) % N;
         end else begin
            m_timer++;
         end
      end
   endtask

   // One clock cycle: called just after a falling edge, returns after the next falling edge
   task automatic step();
      logic [3:0] exp_rdy;
      pack();
      #1;
      last_g  = model_pick();
      exp_rdy = (last_g < 0) ? 4'b0000 : 4'(1 << last_g);
      last_rdy = req_ready;
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
      @(posedge clk);
      model_update(last_g);
      @(negedge clk);
      chk("q", {24'd0, q}, {24'd0, m_q});
      chk("locked", {31'd0, locked}, {31'd0, m_locked});
      chk("owner", {30'd0, owner}, 32'(LOCK_ON ? m_owner : 0));
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < N; i++)
         set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
      pack();
      #1;
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_q", {24'd0, q}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      clear_reqs();
      model_reset();
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      clear_reqs();
      pack();
      model_reset();
      @(negedge clk);

      // Reset then idle
      do_reset();
      repeat (3) step();
      chk("idle_q", {24'd0, q}, 32'h00);

      // Single requester SET / TOGGLE / RESET
      set_req(0, 1'b1, 2'b10, 8'h0F, 1'b0); step();
      chk("set_rdy", {28'd0, last_rdy}, 32'h1);
      chk("set_q", {24'd0, q}, 32'h0F);
      set_req(0, 1'b1, 2'b01, 8'hFF, 1'b0); step();
      chk("tog_rdy", {28'd0, last_rdy}, 32'h1);
      chk("tog_q", {24'd0, q}, 32'hF0);
      set_req(0, 1'b1, 2'b11, 8'h30, 1'b0); step();
      chk("clr_rdy", {28'd0, last_rdy}, 32'h1);
      chk("clr_q", {24'd0, q}, 32'hC0);

      // Round-robin fairness, all valid with NOP
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b00, 8'hFF, 1'b0);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_order", {28'd0, last_rdy}, 32'(1 << (k % N)));
      end

      // Enable gating
      do_reset();
      enable = 1'b0;
      set_req(1, 1'b1, 2'b01, 8'h01, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("gate_rdy", {28'd0, last_rdy}, 32'h0);
         chk("gate_q", {24'd0, q}, 32'h00);
      end
      enable = 1'b1;
      step();
      chk("ungate_rdy", {28'd0, last_rdy}, 32'h2);
      chk("ungate_q", {24'd0, q}, 32'h01);

      // Reset in the middle of activity
      set_req(1, 1'b1, 2'b10, 8'hA0, 1'b0);
      pack();
      @(posedge clk);
      model_update(1);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_q", {24'd0, q}, 32'h00);
      chk("midrst_rdy", {28'd0, req_ready}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      clear_reqs();
      model_reset();

`ifdef T_FF_BANK_ARB_LOCK_EN
      // Lock burst: req2 owns the bank while req0 waits
      do_reset();
      set_req(1, 1'b1, 2'b00, 8'h00, 1'b0); step();
      set_req(1, 1'b0, 2'b00, 8'h00, 1'b0);
      set_req(0, 1'b1, 2'b00, 8'h00, 1'b0);
      set_req(2, 1'b1, 2'b10, 8'h01, 1'b1); step();
      chk("lk_g1", {28'd0, last_rdy}, 32'h4);
      chk("lk_locked", {31'd0, locked}, 32'h1);
      chk("lk_owner", {30'd0, owner}, 32'h2);
      set_req(2, 1'b1, 2'b01, 8'h02, 1'b1); step();
      chk("lk_g2", {28'd0, last_rdy}, 32'h4);
      set_req(2, 1'b1, 2'b01, 8'h04, 1'b0); step();
      chk("lk_g3", {28'd0, last_rdy}, 32'h4);
      chk("lk_q", {24'd0, q}, 32'h07);
      chk("lk_unlocked", {31'd0, locked}, 32'h0);
      set_req(2, 1'b0, 2'b00, 8'h00, 1'b0); step();
      chk("lk_req0", {28'd0, last_rdy}, 32'h1);

      // Lock timeout
      do_reset();
      set_req(2, 1'b1, 2'b00, 8'h00, 1'b0); step();
      set_req(2, 1'b0, 2'b00, 8'h00, 1'b0);
      set_req(3, 1'b1, 2'b10, 8'h80, 1'b1); step();
      chk("to_locked", {31'd0, locked}, 32'h1);
      chk("to_owner", {30'd0, owner}, 32'h3);
      set_req(3, 1'b0, 2'b00, 8'h00, 1'b0);
      set_req(0, 1'b1, 2'b01, 8'h01, 1'b0);
      repeat (LM - 1) step();
      chk("to_still", {31'd0, locked}, 32'h1);
      chk("to_stall", {28'd0, last_rdy}, 32'h0);
      step();
      chk("to_release", {31'd0, locked}, 32'h0);
      step();
      chk("to_req0", {28'd0, last_rdy}, 32'h1);
      chk("to_q", {24'd0, q}, 32'h81);

      // Reset while locked
      set_req(0, 1'b0, 2'b00, 8'h00, 1'b0);
      set_req(3, 1'b1, 2'b10, 8'h02, 1'b1); step();
      chk("rl_locked", {31'd0, locked}, 32'h1);
      reset = 1'b1;
      #1;
      chk("rl_q", {24'd0, q}, 32'h00);
      chk("rl_locked0", {31'd0, locked}, 32'h0);
      chk("rl_owner", {30'd0, owner}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      clear_reqs();
      model_reset();
`endif

      // Randomized traffic obeying the hold-until-accepted rule
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         enable = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(0, 5) == 0)
               set_req(i, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 3) == 0));
         end
         step();
         if (last_g >= 0) v[last_g] = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
